// File: rtl/hyperbus_clk_pkg.sv
// Shared types and the phase-decode helper for the HyperBus multi-phase clock generator.
package hyperbus_clk_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } clk_gen_state_e;

    // Level of phase k while the generator sits in the given slot.
    // Phase k is high for the half period starting one slot after it is "reached",
    // so phase 0 is high in slots 1..NumPhases/2 and each later phase lags by one slot.
    // num_phases is a power of two, so the modulo reduces to a mask.
    function automatic logic phase_level(input logic [31:0] slot,
                                         input logic [31:0] k,
                                         input logic [31:0] num_phases);
        logic [31:0] diff;
        diff = (slot - k) & (num_phases - 32'd1);
        return (diff >= 32'd1) && (diff <= (num_phases >> 1));
    endfunction

endpackage

// File: rtl/hyperbus_clk_gen_prog_slot_cnt.sv
// Position/slot counters and divide-ratio register for the multi-phase clock generator.
// The counters clear whenever counting is disabled, so a fresh start always begins
// at the top of a period.
module hyperbus_clk_slot_cnt #(
    parameter int NumPhases  = 4,
    parameter int DivWidth   = 8,
    parameter int DefaultDiv = 1,
    parameter int SlotW      = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                count_en_i,
    input  logic                load_i,
    input  logic [DivWidth-1:0] load_div_i,
    output logic [SlotW-1:0]    slot_d_o,
    output logic                boundary_o,
    output logic [DivWidth-1:0] div_o
);

    logic [DivWidth-1:0] pos_q, pos_d;
    logic [DivWidth-1:0] div_q, div_d;
    logic [SlotW-1:0]    slot_q, slot_d;
    logic                pos_last;
    logic                slot_last;

    assign pos_last  = (pos_q == (div_q - DivWidth'(1)));
    assign slot_last = (slot_q == SlotW'(NumPhases - 1));

    // Next position/slot; a new ratio is clamped to at least 1 and applied from the next period.
    always_comb begin
        pos_d  = pos_q;
        slot_d = slot_q;
        div_d  = div_q;
        if (!count_en_i) begin
            pos_d  = '0;
            slot_d = '0;
        end else if (pos_last) begin
            pos_d  = '0;
            slot_d = slot_q + SlotW'(1);
        end else begin
            pos_d = pos_q + DivWidth'(1);
        end
        if (load_i) begin
            div_d = (load_div_i == '0) ? DivWidth'(1) : load_div_i;
        end
    end

    // Counter and ratio registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pos_q  <= '0;
            slot_q <= '0;
            div_q  <= DivWidth'(DefaultDiv);
        end else begin
            pos_q  <= pos_d;
            slot_q <= slot_d;
            div_q  <= div_d;
        end
    end

    assign slot_d_o   = slot_d;
    assign boundary_o = count_en_i & pos_last & slot_last;
    assign div_o      = div_q;

endmodule

// File: rtl/hyperbus_clk_gen_prog.sv
// Programmable multi-phase clock generator: run/stop FSM, ratio handshake and
// registered phase outputs. Stops only at a period boundary so no runt pulses appear.
//
// state    | meaning
// IDLE     | counters cleared, outputs parked at the reset pattern
// RUN      | counting, outputs toggling
// STOPPING | run request dropped, finishing the current period
module hyperbus_clk_gen_prog
    import hyperbus_clk_pkg::*;
#(
    parameter int NumPhases  = 4,
    parameter int DivWidth   = 8,
    parameter int DefaultDiv = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic [DivWidth-1:0]  cfg_div_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    output logic [NumPhases-1:0] clk_o,
    output logic                 running_o,
    output logic [DivWidth-1:0]  cur_div_o
);

    localparam int SlotW = (NumPhases > 1) ? $clog2(NumPhases) : 1;
    // Parked pattern: lower half of the phases low, upper half high (slot 0 decode).
    localparam logic [NumPhases-1:0] ClkRst = {{(NumPhases/2){1'b1}}, {(NumPhases/2){1'b0}}};

    clk_gen_state_e       state_q, state_d;
    logic                 running_q;
    logic                 idle_open_q;
    logic [NumPhases-1:0] clk_q, clk_d;
    logic [SlotW-1:0]     slot_d;
    logic                 boundary;
    logic                 count_en;
    logic                 accept;

    assign count_en = (state_q != IDLE);

    // A ratio is taken any cycle in IDLE (once out of reset) or at the last cycle of a period.
    assign accept = cfg_valid_i & ((state_q == IDLE) ? idle_open_q : boundary);

    hyperbus_clk_slot_cnt #(
        .NumPhases  (NumPhases),
        .DivWidth   (DivWidth),
        .DefaultDiv (DefaultDiv),
        .SlotW      (SlotW)
    ) u_slot_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .count_en_i (count_en),
        .load_i     (accept),
        .load_div_i (cfg_div_i),
        .slot_d_o   (slot_d),
        .boundary_o (boundary),
        .div_o      (cur_div_o)
    );

    // Run/stop transitions; dropping en_i on the boundary cycle parks immediately.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (en_i) state_d = RUN;
            end
            RUN: begin
                if (!en_i) state_d = boundary ? IDLE : STOPPING;
            end
            STOPPING: begin
                if (en_i)          state_d = RUN;
                else if (boundary) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Phase decode of the slot being entered, so each output flop changes with the slot.
    always_comb begin
        clk_d = '0;
        for (int k = 0; k < NumPhases; k++) begin
            clk_d[k] = phase_level(32'(slot_d), 32'(k), 32'(NumPhases));
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            running_q   <= 1'b0;
            idle_open_q <= 1'b0;
            clk_q       <= ClkRst;
        end else begin
            state_q     <= state_d;
            running_q   <= (state_d != IDLE);
            idle_open_q <= (state_d == IDLE);
            clk_q       <= clk_d;
        end
    end

    assign cfg_ready_o = accept;
    assign clk_o       = clk_q;
    assign running_o   = running_q;

endmodule
